// File: rtl/add_result_fifo.sv
// add_result_fifo: circular FIFO that captures {carry, data} adder results
// and hands them downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_data/in_carry   push side (no backpressure)
//   out_valid/out_ready   pop handshake
//   out_data/out_carry    head entry (combinational read at rd_ptr)
//   count/full            occupancy, 0..DEPTH
//   overflow/clr_ovf      sticky drop flag and its synchronous clear
module add_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT = (AW+1)'(1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            drop;
  logic [WIDTH:0]  head;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;

  // Gated so every output reads 0 while empty or in reset, even
  // though the storage itself is never cleared.
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = head[WIDTH-1:0];
  assign out_carry = head[WIDTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_carry, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // A fresh drop beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_result_fifo.sv
// tb_add_result_fifo: scoreboard bench for add_result_fifo.
// Driver models occupancy/overflow; monitor checks popped entries.
module tb_add_result_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_carry = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic [3:0]       count;
  logic             full;
  logic             overflow;
  logic             clr_ovf = 1'b0;

  int total = 0;
  int bad = 0;

  logic [WIDTH:0] exp_q[$];
  int             m_count = 0;
  logic           m_ovf = 1'b0;

  always #5 clk = ~clk;

  add_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry),
    .count(count), .full(full), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compares every accepted head against the scoreboard and
  // checks the head is held while stalled.
  logic           stall_seen = 1'b0;
  logic [WIDTH:0] stall_val = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_seen = 1'b0;
      end else if (out_valid) begin
        if (stall_seen) begin
          check("hold", int'({out_carry, out_data}), int'(stall_val));
        end
        if (out_ready) begin
          stall_seen = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_pop", 1, 0);
          end else begin
            check("pop_data", int'({out_carry, out_data}),
                  int'(exp_q.pop_front()));
          end
        end else begin
          stall_seen = 1'b1;
          stall_val = {out_carry, out_data};
        end
      end else begin
        stall_seen = 1'b0;
      end
    end
  end

  // One clock of stimulus; the model decides what the edge should do.
  task automatic cyc(input logic iv, input logic [WIDTH:0] val,
                     input logic rdy, input logic clr);
    logic p_pop, p_push, p_drop;
    in_valid = iv;
    in_carry = val[WIDTH];
    in_data = val[WIDTH-1:0];
    out_ready = rdy;
    clr_ovf = clr;
    @(posedge clk);
    p_pop = (m_count > 0) && rdy;
    p_push = iv && ((m_count < DEPTH) || p_pop);
    p_drop = iv && !p_push;
    if (p_push) exp_q.push_back(val);
    m_count = m_count + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
    if (p_drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    check("count", int'(count), m_count);
    check("full", int'(full), (m_count == DEPTH) ? 1 : 0);
    check("out_valid", int'(out_valid), (m_count != 0) ? 1 : 0);
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  function automatic logic [WIDTH:0] sum(input int a, input int b);
    return (WIDTH+1)'(a + b);
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (m_count > 0 && n < 4 * DEPTH) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_done", m_count, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_data", int'(out_data), 0);
    rst_n = 1'b1;

    // 1: simple push, 1-cycle latency
    cyc(1'b1, sum(10, 20), 1'b0, 1'b0);
    check("t1_data", int'(out_data), 30);
    check("t1_carry", int'(out_carry), 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    drain();

    // 2: carry kept separate from data
    cyc(1'b1, sum(255, 255), 1'b1, 1'b0);
    check("t2_data", int'(out_data), 254);
    check("t2_carry", int'(out_carry), 1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // 3: fill, drop, drain, clear
    for (int i = 1; i <= 8; i++) cyc(1'b1, (WIDTH+1)'(i), 1'b0, 1'b0);
    cyc(1'b1, (WIDTH+1)'(9), 1'b0, 1'b0);
    drain();
    cyc(1'b0, '0, 1'b0, 1'b1);

    // clear and drop together: set wins
    for (int i = 1; i <= 8; i++) cyc(1'b1, (WIDTH+1)'(i), 1'b0, 1'b0);
    cyc(1'b1, (WIDTH+1)'(99), 1'b0, 1'b1);
    drain();
    cyc(1'b0, '0, 1'b0, 1'b1);

    // 4: full with push and pop every cycle, pointers wrap
    for (int i = 1; i <= 8; i++) cyc(1'b1, (WIDTH+1)'(i), 1'b0, 1'b0);
    for (int i = 10; i <= 29; i++) cyc(1'b1, (WIDTH+1)'(i), 1'b1, 1'b0);
    drain();

    // 5: empty with ready held
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, (WIDTH+1)'(77), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // 6: reset mid-operation
    for (int i = 1; i <= 5; i++) cyc(1'b1, (WIDTH+1)'(40 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("r6_valid", int'(out_valid), 0);
    check("r6_count", int'(count), 0);
    check("r6_data", int'(out_data), 0);
    check("r6_full", int'(full), 0);
    exp_q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, (WIDTH+1)'(7), 1'b0, 1'b0);
    check("t6_data", int'(out_data), 7);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 6,
          sum($urandom_range(0, 255), $urandom_range(0, 255)),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 15) == 0);
    end
    drain();
    @(posedge clk);
    @(negedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
